mem_arbiter: RTL and testbench

Shares the single-ported unified instruction/data memory between the fetch stage (IF) and the memory stage (MEM) of the pipelined RISC datapath. Accepted accesses run through a fixed-latency memory sequence, and the block returns read data or a write acknowledge to the winning requester. While a request is pending it drives the stall signals that freeze the PC and pipeline registers. It sits between the datapath and the memory model and is instantiated inside `datapath`.

---
 rtl/mem_arbiter_if.sv | 34 +++
 rtl/mem_arbiter.sv | 128 ++++++++++++
 tb/tb_mem_arbiter.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// Datapath-side and memory-side signals of the unified-memory arbiter.
// slave: arbiter view; master: requester/memory-model view.
interface mem_arbiter_if #(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DATA_W = 16
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic [DATA_W-1:0] if_rdata;
    logic              if_valid;
    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic [DATA_W-1:0] d_rdata;
    logic              d_valid;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        output if_rdata, if_valid, d_rdata, d_valid,
               mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        input  if_rdata, if_valid, d_rdata, d_valid,
               mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// Arbitrates the single-ported unified memory between fetch (IF) and data (D)
// requesters with a fixed-latency access sequence and round-robin tie-break.
module mem_arbiter #(
    parameter int unsigned ADDR_W  = 16,
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned MEM_LAT = 2
) (
    input  logic         clk,
    input  logic         rst,
    mem_arbiter_if.slave bus,
    output logic         stall_if,
    output logic         stall_pipe,
    output logic         busy,
    output logic [15:0]  conflict_cnt
);

    localparam int unsigned CNT_W  = 4;
    localparam int unsigned CC_W   = 16;
    localparam logic [CC_W-1:0] CC_MAX = '1;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic              w_accept;
    logic              w_grant_d;
    logic              w_conflict;
    logic              w_capture;

    logic [CNT_W-1:0]  r_cnt;
    logic              r_owner_d;
    logic              r_we;
    logic              r_last_d;
    logic              r_mem_en;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;
    logic [DATA_W-1:0] r_if_rdata;
    logic [DATA_W-1:0] r_d_rdata;
    logic              r_if_valid;
    logic              r_d_valid;
    logic [CC_W-1:0]   r_conflict_cnt;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= S_IDLE;
        else      r_state <= w_state_nxt;
    end

    // Next state, grant and capture decisions; a tie goes to whoever lost last
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_grant_d   = 1'b0;
        w_conflict  = 1'b0;
        w_capture   = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_accept   = bus.if_req | bus.d_req;
                w_grant_d  = bus.d_req & (~bus.if_req | ~r_last_d);
                w_conflict = bus.if_req & bus.d_req;
                if (w_accept) w_state_nxt = S_ISSUE;
            end
            S_ISSUE: w_state_nxt = S_WAIT;
            S_WAIT: begin
                if (r_cnt == CNT_W'(1)) begin
                    w_capture   = 1'b1;
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Access latch, memory strobe, read capture and completion pulses
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt          <= '0;
            r_owner_d      <= 1'b0;
            r_we           <= 1'b0;
            r_last_d       <= 1'b0;
            r_mem_en       <= 1'b0;
            r_mem_we       <= 1'b0;
            r_mem_addr     <= '0;
            r_mem_wdata    <= '0;
            r_if_rdata     <= '0;
            r_d_rdata      <= '0;
            r_if_valid     <= 1'b0;
            r_d_valid      <= 1'b0;
            r_conflict_cnt <= '0;
        end else begin
            r_mem_en    <= w_accept;
            r_mem_we    <= w_accept & w_grant_d & bus.d_we;
            r_mem_addr  <= w_accept ? (w_grant_d ? bus.d_addr : bus.if_addr) : '0;
            r_mem_wdata <= (w_accept & w_grant_d & bus.d_we) ? bus.d_wdata : '0;
            if (w_accept) begin
                r_owner_d <= w_grant_d;
                r_we      <= w_grant_d & bus.d_we;
                r_last_d  <= w_grant_d;
            end
            if (r_state == S_ISSUE)     r_cnt <= CNT_W'(MEM_LAT);
            else if (r_state == S_WAIT) r_cnt <= r_cnt - CNT_W'(1);
            if (w_capture && !r_owner_d)          r_if_rdata <= bus.mem_rdata;
            if (w_capture && r_owner_d && !r_we)  r_d_rdata  <= bus.mem_rdata;
            r_if_valid <= w_capture & ~r_owner_d;
            r_d_valid  <= w_capture & r_owner_d;
            if (w_conflict && (r_conflict_cnt != CC_MAX))
                r_conflict_cnt <= r_conflict_cnt + CC_W'(1);
        end
    end

    assign bus.mem_en    = r_mem_en;
    assign bus.mem_we    = r_mem_we;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_mem_wdata;
    assign bus.if_rdata  = r_if_rdata;
    assign bus.d_rdata   = r_d_rdata;
    assign bus.if_valid  = r_if_valid;
    assign bus.d_valid   = r_d_valid;
    assign conflict_cnt  = r_conflict_cnt;

    // Stalls drop in the same cycle as the matching valid pulse
    assign stall_if   = bus.if_req & ~r_if_valid;
    assign stall_pipe = bus.d_req & ~r_d_valid;
    assign busy       = (r_state != S_IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed scoreboard bench for mem_arbiter at MEM_LAT 2 (main), 1 and 15.
module tb_mem_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec = 0;
    int n_err = 0;

    mem_arbiter_if #(.ADDR_W(16), .DATA_W(16)) b2 ();
    mem_arbiter_if #(.ADDR_W(16), .DATA_W(16)) b1 ();
    mem_arbiter_if #(.ADDR_W(16), .DATA_W(16)) b15 ();

    logic s_if2, s_p2, busy2, s_if1, s_p1, busy1, s_if15, s_p15, busy15;
    logic [15:0] cc2, cc1, cc15;

    mem_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_LAT(2)) u2 (
        .clk(clk), .rst(rst), .bus(b2.slave),
        .stall_if(s_if2), .stall_pipe(s_p2), .busy(busy2), .conflict_cnt(cc2));
    mem_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_LAT(1)) u1 (
        .clk(clk), .rst(rst), .bus(b1.slave),
        .stall_if(s_if1), .stall_pipe(s_p1), .busy(busy1), .conflict_cnt(cc1));
    mem_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_LAT(15)) u15 (
        .clk(clk), .rst(rst), .bus(b15.slave),
        .stall_if(s_if15), .stall_pipe(s_p15), .busy(busy15), .conflict_cnt(cc15));

    function automatic logic [15:0] rom(input logic [15:0] a);
        case (a)
            16'h0004: return 16'h1234;
            16'h0006: return 16'h5678;
            16'h0010: return 16'hBEEF;
            default:  return a ^ 16'h5A5A;
        endcase
    endfunction

    // Memory models: read data is valid only in cycle mem_en+LAT, garbage otherwise
    logic [4:0]  m2_cnt = '0, m1_cnt = '0, m15_cnt = '0;
    logic [15:0] m2_a = '0, m1_a = '0, m15_a = '0;
    logic        have_w = 1'b0;
    logic [15:0] w_a = '0, w_d = '0;

    always @(posedge clk) begin
        if (b2.mem_en) begin
            m2_a <= b2.mem_addr; m2_cnt <= 5'd1;
            if (b2.mem_we) begin have_w <= 1'b1; w_a <= b2.mem_addr; w_d <= b2.mem_wdata; end
        end else if (m2_cnt != 5'd0 && m2_cnt != 5'd31) m2_cnt <= m2_cnt + 5'd1;
        if (b1.mem_en) begin m1_a <= b1.mem_addr; m1_cnt <= 5'd1; end
        else if (m1_cnt != 5'd0 && m1_cnt != 5'd31) m1_cnt <= m1_cnt + 5'd1;
        if (b15.mem_en) begin m15_a <= b15.mem_addr; m15_cnt <= 5'd1; end
        else if (m15_cnt != 5'd0 && m15_cnt != 5'd31) m15_cnt <= m15_cnt + 5'd1;
    end

    assign b2.mem_rdata  = (m2_cnt == 5'd2) ? ((have_w && w_a == m2_a) ? w_d : rom(m2_a)) : 16'hDEAD;
    assign b1.mem_rdata  = (m1_cnt == 5'd1) ? rom(m1_a) : 16'hDEAD;
    assign b15.mem_rdata = (m15_cnt == 5'd15) ? rom(m15_a) : 16'hDEAD;

    // Record every mem_en cycle of the main instance
    int          en_n = 0, en_cyc = 0;
    logic [15:0] en_addr = '0, en_wd = '0;
    logic        en_we = 1'b0;
    always @(negedge clk) begin
        if (b2.mem_en) begin
            en_n <= en_n + 1; en_cyc <= cyc;
            en_addr <= b2.mem_addr; en_we <= b2.mem_we; en_wd <= b2.mem_wdata;
        end
    end

    typedef struct {
        logic        is_d;
        logic [15:0] data;
        logic [15:0] addr;
        logic        we;
        logic [15:0] wd;
        int          vcyc;
    } exp_t;
    exp_t sb[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic is_d, input logic [15:0] data, input logic [15:0] addr,
                        input logic we, input logic [15:0] wd, input int vcyc);
        exp_t e;
        e.is_d = is_d; e.data = data; e.addr = addr; e.we = we; e.wd = wd; e.vcyc = vcyc;
        sb.push_back(e);
    endtask

    // Wait for the next completion on the main instance and check it against the queue head
    task automatic wait_pop(input bit drop);
        exp_t e;
        bit   got = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (b2.if_valid || b2.d_valid) begin got = 1'b1; break; end
            if (sb.size() > 0)
                chk(sb[0].is_d ? "stall_pipe_wait" : "stall_if_wait",
                    sb[0].is_d ? 32'(s_p2) : 32'(s_if2), 32'(1));
        end
        n_vec++;
        assert (got && sb.size() > 0) else begin
            n_err++;
            $error("FAIL valid_wait: got %0d queued %0d at cycle %0d", got, sb.size(), cyc);
        end
        if (!got || sb.size() == 0) return;
        e = sb.pop_front();
        chk("valid_owner", 32'({b2.d_valid, b2.if_valid}), e.is_d ? 32'(2) : 32'(1));
        chk("valid_cycle", 32'(cyc), 32'(e.vcyc));
        chk("rdata", e.is_d ? 32'(b2.d_rdata) : 32'(b2.if_rdata), 32'(e.data));
        chk("stall_at_valid", e.is_d ? 32'(s_p2) : 32'(s_if2), 32'(0));
        chk("mem_en_cycle", 32'(en_cyc), 32'(e.vcyc - 3));
        chk("mem_addr", 32'(en_addr), 32'(e.addr));
        chk("mem_we", 32'(en_we), 32'(e.we));
        if (e.we) chk("mem_wdata", 32'(en_wd), 32'(e.wd));
        if (drop) begin
            @(posedge clk); #1;
            if (e.is_d) b2.d_req = 1'b0; else b2.if_req = 1'b0;
        end
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    int c, n0, v1, v15;
    logic [15:0] rd1, rd15;

    initial begin
        b2.if_req = 0; b2.if_addr = 0; b2.d_req = 0; b2.d_we = 0; b2.d_addr = 0; b2.d_wdata = 0;
        b1.if_req = 0; b1.if_addr = 0; b1.d_req = 0; b1.d_we = 0; b1.d_addr = 0; b1.d_wdata = 0;
        b15.if_req = 0; b15.if_addr = 0; b15.d_req = 0; b15.d_we = 0; b15.d_addr = 0; b15.d_wdata = 0;
        repeat (3) step();
        chk("rst_mem_bus", 32'({b2.mem_en, b2.mem_we, b2.mem_addr}), 32'(0));
        chk("rst_mem_wdata", 32'(b2.mem_wdata), 32'(0));
        chk("rst_rdata", {b2.if_rdata, b2.d_rdata}, 32'(0));
        chk("rst_valid_busy", 32'({b2.if_valid, b2.d_valid, busy2}), 32'(0));
        chk("rst_conflict", 32'(cc2), 32'(0));
        rst = 1'b1;
        step();

        // Single fetch
        c = cyc; b2.if_addr = 16'h0004; b2.if_req = 1'b1;
        push(1'b0, 16'h1234, 16'h0004, 1'b0, 16'h0, c + 4);
        wait_pop(1'b1);
        step();

        // Simultaneous requests after reset: D first, then IF
        c = cyc; b2.d_addr = 16'h0010; b2.d_we = 1'b0; b2.if_addr = 16'h0006;
        b2.d_req = 1'b1; b2.if_req = 1'b1;
        push(1'b1, 16'hBEEF, 16'h0010, 1'b0, 16'h0, c + 4);
        push(1'b0, 16'h5678, 16'h0006, 1'b0, 16'h0, c + 9);
        wait_pop(1'b1);
        wait_pop(1'b1);
        chk("conflict_one", 32'(cc2), 32'(1));
        step();

        // Both held: D, IF, D, IF, one pair per 10 cycles
        c = cyc; b2.if_addr = 16'h0004; b2.d_req = 1'b1; b2.if_req = 1'b1;
        push(1'b1, 16'hBEEF, 16'h0010, 1'b0, 16'h0, c + 4);
        push(1'b0, 16'h1234, 16'h0004, 1'b0, 16'h0, c + 9);
        push(1'b1, 16'hBEEF, 16'h0010, 1'b0, 16'h0, c + 14);
        push(1'b0, 16'h1234, 16'h0004, 1'b0, 16'h0, c + 19);
        repeat (4) wait_pop(1'b0);
        step();
        b2.d_req = 1'b0; b2.if_req = 1'b0;
        chk("conflict_five", 32'(cc2), 32'(5));
        step();

        // Store: one write strobe, d_rdata holds, then read it back
        n0 = en_n;
        c = cyc; b2.d_addr = 16'h0020; b2.d_wdata = 16'h00AA; b2.d_we = 1'b1; b2.d_req = 1'b1;
        push(1'b1, 16'hBEEF, 16'h0020, 1'b1, 16'h00AA, c + 4);
        wait_pop(1'b1);
        chk("store_en_once", 32'(en_n - n0), 32'(1));
        step();
        c = cyc; b2.d_we = 1'b0; b2.d_wdata = 16'h0; b2.d_req = 1'b1;
        push(1'b1, 16'h00AA, 16'h0020, 1'b0, 16'h0, c + 4);
        wait_pop(1'b1);
        step();

        // Reset during WAIT abandons the access; pending fetch restarts after release
        b2.if_addr = 16'h0006; b2.if_req = 1'b1;
        step(); step();
        chk("pre_rst_busy", 32'(busy2), 32'(1));
        rst = 1'b0; #1;
        chk("mid_rst_en_valid", 32'({b2.mem_en, b2.if_valid, b2.d_valid}), 32'(0));
        chk("mid_rst_busy", 32'(busy2), 32'(0));
        chk("mid_rst_state", {cc2, b2.if_rdata}, 32'(0));
        step(); step();
        rst = 1'b1;
        c = cyc;
        push(1'b0, 16'h5678, 16'h0006, 1'b0, 16'h0, c + 4);
        wait_pop(1'b1);
        step();

        // Latency at MEM_LAT 1 and 15
        c = cyc; v1 = -1; v15 = -1; rd1 = '0; rd15 = '0;
        b1.if_addr = 16'h0040; b1.if_req = 1'b1;
        b15.if_addr = 16'h0042; b15.if_req = 1'b1;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (cyc == c + 1) chk("lat_busy", 32'({busy1, busy15}), 32'(3));
            if (b1.if_valid && v1 < 0) begin
                v1 = cyc; rd1 = b1.if_rdata;
                chk("lat1_stall_at_valid", 32'({s_if1, s_p1}), 32'(0));
            end
            if (b15.if_valid && v15 < 0) begin
                v15 = cyc; rd15 = b15.if_rdata;
                chk("lat15_stall_at_valid", 32'({s_if15, s_p15}), 32'(0));
            end
            step();
            if (v1 >= 0) b1.if_req = 1'b0;
            if (v15 >= 0) b15.if_req = 1'b0;
        end
        chk("lat1_valid_cycle", 32'(v1), 32'(c + 3));
        chk("lat1_rdata", 32'(rd1), 32'(rom(16'h0040)));
        chk("lat15_valid_cycle", 32'(v15), 32'(c + 17));
        chk("lat15_rdata", 32'(rd15), 32'(rom(16'h0042)));
        chk("lat15_conflict", 32'(cc15), 32'(0));

        // Conflict counter saturation, preloaded near the top while busy
        c = cyc; b1.if_req = 1'b1; b1.d_req = 1'b1; b1.d_addr = 16'h0050;
        step();
        chk("sat_first", 32'(cc1), 32'(1));
        force u1.r_conflict_cnt = 16'hFFFE;
        #1;
        release u1.r_conflict_cnt;
        while (cyc < c + 6) step();
        chk("sat_reach_max", 32'(cc1), 32'(16'hFFFF));
        while (cyc < c + 10) step();
        chk("sat_hold_max", 32'(cc1), 32'(16'hFFFF));
        b1.if_req = 1'b0; b1.d_req = 1'b0;
        repeat (6) step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not complete by %0t", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
